// File: rtl/riscv_mmio_pkg.sv
// Shared MMIO constants for the UART transmitter: base address, register
// offsets, STATUS bit positions and transmit FSM state codes.
package riscv_mmio_pkg;

    localparam logic [31:0] UART_BASE = 32'h0000_0400;

    // Word offsets inside the 16-byte register window (addr[3:2])
    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_BAUD   = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    // STATUS register bit positions
    localparam int unsigned ST_BUSY   = 0;
    localparam int unsigned ST_FULL   = 1;
    localparam int unsigned ST_EMPTY  = 2;
    localparam int unsigned ST_OVF    = 3;
    localparam int unsigned ST_CNT_LO = 4;

    localparam int unsigned BAUD_W   = 16;
    localparam logic [15:0] BAUD_MIN = 16'd2;

    // Transmit FSM states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // Divider values below the minimum are stored as the minimum
    function automatic logic [15:0] clamp_baud(input logic [15:0] v);
        return (v < BAUD_MIN) ? BAUD_MIN : v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr];

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUD registers on the
// CPU load/store bus, a byte FIFO and a serialiser driving tx (LSB first).
module uart_tx_mmio
    import riscv_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = UART_BASE,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] read_data,
    output logic        sel,
    output logic        tx,
    output logic        tx_busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]        offset;
    logic              wr_en;
    logic              push_req;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [7:0]        fifo_rdata;
    logic              overflow;
    logic [BAUD_W-1:0] baud;
    logic [3:0]        status_count;
    logic [31:0]       status;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [15:0]       timer;
    logic [15:0]       timer_next;
    logic [15:0]       bit_div;
    logic [15:0]       bit_div_next;
    logic [7:0]        shift;
    logic [7:0]        shift_next;
    logic [2:0]        bit_cnt;
    logic [2:0]        bit_cnt_next;
    logic              tx_next;
    logic              timer_done;
    logic              unused_bits;

    assign sel         = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset      = addr[3:2];
    assign wr_en       = sel & MemWrite;
    assign push_req    = wr_en & (offset == OFF_TXDATA);
    assign timer_done  = (timer == 16'd0);
    assign tx_busy     = (state != IDLE) | ~fifo_empty;
    assign unused_bits = ^{addr[1:0], write_data[31:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (fifo_pop),
        .wdata (write_data[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky overflow flag; a dropped push outranks a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push_req & fifo_full & ~fifo_pop) begin
            overflow <= 1'b1;
        end else if (wr_en & (offset == OFF_STATUS) & write_data[ST_OVF]) begin
            overflow <= 1'b0;
        end
    end

    // Bit-rate divider register, consumed at the start of each frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud <= 16'(CLKS_PER_BIT);
        end else if (wr_en & (offset == OFF_BAUD)) begin
            baud <= clamp_baud(write_data[15:0]);
        end
    end

    // STATUS image with the FIFO count saturated to four bits
    always_comb begin
        status_count = (32'(fifo_count) > 32'd15) ? 4'hF : 4'(fifo_count);
        status                  = '0;
        status[ST_BUSY]         = tx_busy;
        status[ST_FULL]         = fifo_full;
        status[ST_EMPTY]        = fifo_empty;
        status[ST_OVF]          = overflow;
        status[ST_CNT_LO +: 4]  = status_count;
    end

    // Register read mux; zero unless a selected load
    always_comb begin
        read_data = '0;
        if (sel & MemRead) begin
            case (offset)
                OFF_STATUS:           read_data = status;
                OFF_BAUD:             read_data = {16'd0, baud};
                OFF_TXDATA, OFF_RSVD: read_data = '0;
                default:              read_data = '0;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next-state: STOP chains straight into START when more data waits
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty) state_next = START;
            START:   if (timer_done) state_next = DATA;
            DATA:    if (timer_done && (bit_cnt == 3'd7)) state_next = STOP;
            STOP:    if (timer_done) state_next = fifo_empty ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: bit timer, shifter, FIFO pop and next tx level
    always_comb begin
        fifo_pop     = 1'b0;
        shift_next   = shift;
        bit_div_next = bit_div;
        timer_next   = timer;
        bit_cnt_next = bit_cnt;
        tx_next      = 1'b1;
        case (state)
            START: begin
                tx_next = 1'b0;
                if (timer_done) begin
                    timer_next   = bit_div - 16'd1;
                    bit_cnt_next = 3'd0;
                    tx_next      = shift[0];
                end else begin
                    timer_next = timer - 16'd1;
                end
            end
            DATA: begin
                tx_next = shift[0];
                if (timer_done) begin
                    timer_next = bit_div - 16'd1;
                    if (bit_cnt == 3'd7) begin
                        tx_next = 1'b1;
                    end else begin
                        shift_next   = {1'b0, shift[7:1]};
                        tx_next      = shift[1];
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end else begin
                    timer_next = timer - 16'd1;
                end
            end
            STOP: begin
                if (!timer_done) timer_next = timer - 16'd1;
            end
            default: ;
        endcase
        if (!fifo_empty && ((state == IDLE) || ((state == STOP) && timer_done))) begin
            fifo_pop     = 1'b1;
            shift_next   = fifo_rdata;
            bit_div_next = baud;
            timer_next   = baud - 16'd1;
            tx_next      = 1'b0;
        end
    end

    // Serialiser datapath registers; tx idles high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer   <= '0;
            bit_div <= 16'(CLKS_PER_BIT);
            shift   <= '0;
            bit_cnt <= '0;
            tx      <= 1'b1;
        end else begin
            timer   <= timer_next;
            bit_div <= bit_div_next;
            shift   <= shift_next;
            bit_cnt <= bit_cnt_next;
            tx      <= tx_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: a queue-based line model checked every cycle plus
// directed register and waveform checks with hand-computed values.
module tb_uart_tx_mmio;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE    = 32'h0000_0400;
    localparam logic [27:0] BASE_HI = 28'h000_0040;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic [31:0] addr       = '0;
    logic [31:0] write_data = '0;
    logic        MemRead    = 1'b0;
    logic        MemWrite   = 1'b0;
    logic [31:0] read_data;
    logic        sel;
    logic        tx;
    logic        tx_busy;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .write_data (write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .read_data  (read_data),
        .sel        (sel),
        .tx         (tx),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_fifo [$];
    bit          m_wave [$];
    int unsigned m_baud = CPB;
    bit          m_ovf  = 1'b0;
    bit          m_tx   = 1'b1;
    bit          m_line = 1'b0;
    logic [7:0]  mb;
    bit          mv;

    function automatic bit m_busy();
        return m_line || (m_fifo.size() != 0);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        if (a[31:4] == BASE_HI) begin
            if (a[3:2] == 2'd1)
                r = {24'd0, 4'(m_fifo.size()), m_ovf, (m_fifo.size() == 0),
                     (m_fifo.size() == DEPTH), m_busy()};
            else if (a[3:2] == 2'd2)
                r = 32'(m_baud);
        end
        return r;
    endfunction

    // Model: a frame is a list of 10*baud line samples started whenever the line is free
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_fifo.delete();
            m_wave.delete();
            m_baud = CPB;
            m_ovf  = 1'b0;
            m_tx   = 1'b1;
            m_line = 1'b0;
        end else begin
            if ((m_wave.size() == 0) && (m_fifo.size() != 0)) begin
                mb = m_fifo.pop_front();
                for (int i = 0; i < 10; i++) begin
                    mv = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : mb[i-1];
                    repeat (m_baud) m_wave.push_back(mv);
                end
            end
            if (m_wave.size() != 0) begin
                m_tx   = m_wave.pop_front();
                m_line = 1'b1;
            end else begin
                m_tx   = 1'b1;
                m_line = 1'b0;
            end
            if (MemWrite && (addr[31:4] == BASE_HI)) begin
                case (addr[3:2])
                    2'd0: if (m_fifo.size() < DEPTH) m_fifo.push_back(write_data[7:0]);
                          else m_ovf = 1'b1;
                    2'd1: if (write_data[3]) m_ovf = 1'b0;
                    2'd2: m_baud = (write_data[15:0] < 16'd2) ? 2 : int'(write_data[15:0]);
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model
    initial forever begin
        @(negedge clk);
        if (check_en) begin
            check("tx", 32'(tx), 32'(m_tx));
            check("tx_busy", 32'(tx_busy), 32'(m_busy()));
            check("sel", 32'(sel), 32'(addr[31:4] == BASE_HI));
            check("read_data", read_data, MemRead ? m_read(addr) : 32'd0);
        end
    end

    // ---------------- bus helpers (called at posedge+1) ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr       = a;
        write_data = d;
        MemWrite   = 1'b1;
        tick(1);
        MemWrite   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr    = a;
        MemRead = 1'b1;
        #1;
        d = read_data;
        tick(1);
        MemRead = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while ((tx_busy === 1'b1) && (n < bound)) begin
            tick(1);
            n++;
        end
        check("idle_timeout", 32'(tx_busy), 32'd0);
    endtask

    // seq[i] is the expected line level for bit slot i (start, d0..d7, stop)
    task automatic capture_frame(input string name, input logic [9:0] seq);
        for (int i = 0; i < 10 * CPB; i++) begin
            tick(1);
            check(name, 32'(tx), 32'(seq[i / CPB]));
        end
    endtask

    logic [31:0] d;
    int          n;

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        check_en = 1'b1;

        // Reset state
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        bus_read(BASE + 32'h4, d);  check("rst_status", d, 32'h0000_0004);
        bus_read(BASE + 32'h8, d);  check("rst_baud", d, 32'd4);
        bus_write(BASE + 32'hC, 32'hFFFF_FFFF);
        bus_read(BASE + 32'hC, d);  check("rsvd_read", d, 32'd0);
        bus_read(BASE + 32'h0, d);  check("txdata_read", d, 32'd0);
        bus_read(32'h0000_0800, d); check("unsel_read", d, 32'd0);

        // Single frame 0xA5
        bus_write(BASE, 32'h0000_00A5);
        check("a5_latency_high", 32'(tx), 32'd1);
        capture_frame("a5_wave", 10'h34A);
        tick(1);
        check("a5_done_busy", 32'(tx_busy), 32'd0);

        // Three back-to-back frames, 120 clocks with no gap
        bus_write(BASE, 32'h11);
        bus_write(BASE, 32'h22);
        bus_write(BASE, 32'h33);
        wait_idle(400, n);
        check("b2b_cycles", 32'(n), 32'd119);
        bus_read(BASE + 32'h4, d);  check("b2b_status", d, 32'h0000_0004);

        // Overflow: one in the shifter, four queued, two dropped
        for (int i = 1; i <= 7; i++) bus_write(BASE, 32'(i));
        bus_read(BASE + 32'h4, d);  check("ovf_status", d, 32'h0000_004B);
        bus_write(BASE + 32'h4, 32'h8);
        bus_read(BASE + 32'h4, d);  check("ovf_cleared", d, 32'h0000_0043);
        wait_idle(800, n);
        bus_read(BASE + 32'h4, d);  check("ovf_drained", d, 32'h0000_0004);

        // BAUD change mid-frame only affects the following frame
        bus_write(BASE, 32'h3C);
        bus_write(BASE, 32'hC3);
        bus_write(BASE + 32'h8, 32'd8);
        tick(38); check("f1_stop", 32'(tx), 32'd1);
        tick(1);  check("f2_start", 32'(tx), 32'd0);
        tick(7);  check("f2_start_long", 32'(tx), 32'd0);
        tick(1);  check("f2_bit0", 32'(tx), 32'd1);
        wait_idle(400, n);
        bus_read(BASE + 32'h8, d);  check("baud_8", d, 32'd8);
        bus_write(BASE + 32'h8, 32'd1);
        bus_read(BASE + 32'h8, d);  check("baud_clamp", d, 32'd2);
        bus_write(BASE + 32'h8, 32'd4);
        bus_read(BASE + 32'h8, d);  check("baud_4", d, 32'd4);

        // Reset during data bit 3 discards frame and queue
        bus_write(BASE, 32'h00);
        bus_write(BASE, 32'h77);
        tick(16);
        #2;
        check("pre_rst_tx", 32'(tx), 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        tick(2);
        reset = 1'b0;
        bus_read(BASE + 32'h4, d);  check("post_rst_status", d, 32'h0000_0004);
        bus_write(BASE, 32'h5A);
        capture_frame("5a_wave", 10'h2B4);
        tick(1);
        check("5a_done_busy", 32'(tx_busy), 32'd0);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop if the run never reaches its summary
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1);
    end

endmodule
